// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
//
// EX-stage branch resolver plus a bimodal branch history table (BHT).
//
// The resolver compares the forwarded operands for the selected condition and
// drives the taken outcome combinationally for the same-cycle flush path. The
// BHT holds one 2-bit saturating counter per entry. It is read by the IF-stage
// PC and trained by the EX-stage resolution. A registered mispredict pulse and
// two saturating statistics counters report the prediction quality.
//
// Ports:
//   i_clk            clock, all state updates on the rising edge
//   i_rst            asynchronous active-high reset
//   i_if_pc          fetch PC used for the prediction lookup
//   o_pred_taken     combinational prediction for i_if_pc
//   i_ex_valid       a branch-class instruction occupies EX this cycle
//   i_stall          EX held; suppresses training and counting
//   i_ex_pc          PC of the EX instruction (selects the entry to train)
//   i_ex_pred_taken  prediction the EX instruction carried from IF
//   i_data1          rs operand (forwarded)
//   i_data2          rt operand (forwarded)
//   i_branch         condition select
//   o_taken          combinational resolved outcome
//   o_mispredict     previous cycle's resolution disagreed with its prediction
//   o_br_count       resolved branches, saturating
//   o_miss_count     mispredictions, saturating
// ----------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PC_W-1:0]  i_if_pc,
    output logic             o_pred_taken,
    input  logic             i_ex_valid,
    input  logic             i_stall,
    input  logic [PC_W-1:0]  i_ex_pc,
    input  logic             i_ex_pred_taken,
    input  logic [XLEN-1:0]  i_data1,
    input  logic [XLEN-1:0]  i_data2,
    input  logic [2:0]       i_branch,
    output logic             o_taken,
    output logic             o_mispredict,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_miss_count
);

    localparam int unsigned Entries = 1 << IDX_W;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Condition select encodings.
    localparam logic [2:0] BrNone = 3'b000;
    localparam logic [2:0] BrBeq  = 3'b001;
    localparam logic [2:0] BrBne  = 3'b010;
    localparam logic [2:0] BrBlez = 3'b011;
    localparam logic [2:0] BrBgtz = 3'b100;
    localparam logic [2:0] BrBltz = 3'b101;
    localparam logic [2:0] BrBgez = 3'b110;

    logic [1:0]       bht_q [Entries];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ex_ctr;
    logic [1:0]       ex_ctr_next;

    logic             data1_zero;
    logic             data1_neg;
    logic             cond;
    logic             upd;
    logic             miss;

    logic             mispredict_q;
    logic [CNT_W-1:0] br_count_q;
    logic [CNT_W-1:0] miss_count_q;

    // ------------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------------
    // Signed zero-compares reduce to the sign bit and an all-zero test.
    assign data1_zero = (i_data1 == '0);
    assign data1_neg  = i_data1[XLEN-1];

    always_comb begin
        cond = 1'b0;
        case (i_branch)
            BrBeq:   cond = (i_data1 == i_data2);
            BrBne:   cond = (i_data1 != i_data2);
            BrBlez:  cond = data1_neg | data1_zero;
            BrBgtz:  cond = ~data1_neg & ~data1_zero;
            BrBltz:  cond = data1_neg;
            BrBgez:  cond = ~data1_neg;
            default: cond = 1'b0;
        endcase
    end

    assign o_taken = cond & i_ex_valid;

    // ------------------------------------------------------------------------
    // Update enable and mispredict detection
    // ------------------------------------------------------------------------
    assign upd  = i_ex_valid & ~i_stall & (i_branch != BrNone);
    assign miss = upd & (o_taken != i_ex_pred_taken);

    // ------------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------------
    // Word-aligned index: the two low PC bits never select an entry.
    assign if_idx = i_if_pc[IDX_W+1:2];
    assign ex_idx = i_ex_pc[IDX_W+1:2];

    // No bypass: a same-cycle update to the looked-up entry shows up next cycle.
    assign o_pred_taken = bht_q[if_idx][1];

    assign ex_ctr = bht_q[ex_idx];

    always_comb begin
        ex_ctr_next = ex_ctr;
        if (o_taken) begin
            if (ex_ctr != 2'b11) begin
                ex_ctr_next = ex_ctr + 2'b01;
            end
        end else begin
            if (ex_ctr != 2'b00) begin
                ex_ctr_next = ex_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < Entries; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (upd) begin
            bht_q[ex_idx] <= ex_ctr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Mispredict pulse and statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= miss;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_count_q <= '0;
        end else if (upd && (br_count_q != CntMax)) begin
            br_count_q <= br_count_q + CntOne;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            miss_count_q <= '0;
        end else if (miss && (miss_count_q != CntMax)) begin
            miss_count_q <= miss_count_q + CntOne;
        end
    end

    assign o_mispredict = mispredict_q;
    assign o_br_count   = br_count_q;
    assign o_miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    localparam int XLEN  = 32;
    localparam int PC_W  = 32;
    localparam int IDX_W = 6;
    localparam int CNT_W = 4;
    localparam int NENT  = 64;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [PC_W-1:0]  if_pc = '0;
    logic             pred_taken;
    logic             ex_valid = 1'b0;
    logic             stall = 1'b0;
    logic [PC_W-1:0]  ex_pc = '0;
    logic             ex_pred = 1'b0;
    logic [XLEN-1:0]  d1 = '0;
    logic [XLEN-1:0]  d2 = '0;
    logic [2:0]       branch = 3'b000;
    logic             taken;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int bht_m [NENT];
    int br_m;
    int miss_m;
    bit mis_m;

    branch_predict_unit #(
        .XLEN (XLEN),
        .PC_W (PC_W),
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_if_pc        (if_pc),
        .o_pred_taken   (pred_taken),
        .i_ex_valid     (ex_valid),
        .i_stall        (stall),
        .i_ex_pc        (ex_pc),
        .i_ex_pred_taken(ex_pred),
        .i_data1        (d1),
        .i_data2        (d2),
        .i_branch       (branch),
        .o_taken        (taken),
        .o_mispredict   (mispredict),
        .o_br_count     (br_count),
        .o_miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    function automatic bit cond_f(int br, logic [31:0] a, logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (br)
            1:       return a == b;
            2:       return a != b;
            3:       return sa <= 0;
            4:       return sa > 0;
            5:       return sa < 0;
            6:       return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_f(logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic bit pred_f(logic [31:0] pc);
        return bht_m[idx_f(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) bht_m[i] = 1;
        br_m   = 0;
        miss_m = 0;
        mis_m  = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        bit u;
        bit t;
        bit m;
        int ix;
        u  = ex_valid && !stall && (branch != 3'b000);
        t  = ex_valid && cond_f(int'(branch), d1, d2);
        m  = u && (t != ex_pred);
        ix = idx_f(ex_pc);
        @(posedge clk);
        #1;
        if (u) begin
            if (t) bht_m[ix] = (bht_m[ix] == 3) ? 3 : bht_m[ix] + 1;
            else   bht_m[ix] = (bht_m[ix] == 0) ? 0 : bht_m[ix] - 1;
            br_m = (br_m == CMAX) ? CMAX : br_m + 1;
        end
        if (m) miss_m = (miss_m == CMAX) ? CMAX : miss_m + 1;
        mis_m = m;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        stall    = 1'b0;
        branch   = 3'b000;
        ex_pred  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        // Load some state first so reset has something to clear.
        ex_valid = 1'b1; branch = 3'b010; d1 = 32'd1; d2 = 32'd2; ex_pc = 32'h40;
        tick(); tick();
        idle_inputs();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (mispredict !== 1'b0 || br_count !== 4'd0 || miss_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: mis=%b br=%0d miss=%0d required 0/0/0",
                     mispredict, br_count, miss_count);
        end
        for (int pc = 0; pc <= 'hFC; pc += 4) begin
            if_pc = pc;
            #1;
            n_tests++;
            if (pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pred pc=%h: got %b required 0", pc, pred_taken);
            end
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_conditions();
        logic [31:0] a;
        logic [31:0] b;
        bit          exp;
        idle_inputs();
        stall    = 1'b1;
        ex_valid = 1'b1;
        for (int br = 0; br < 8; br++) begin
            for (int k = 0; k < 2; k++) begin
                d1 = (k == 0) ? 32'hFFFF_FFFF : 32'h0;
                d2 = 32'h0000_0001;
                branch = br[2:0];
                #1;
                exp = cond_f(br, d1, d2);
                n_tests++;
                if (taken !== exp) begin
                    n_fail++;
                    $display("FAIL cond br=%0d d1=%h: got %b required %b", br, d1, taken, exp);
                end
            end
        end
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'h0;
                1: a = {1'b0, a[30:0]};
                default: ;
            endcase
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            d1 = a; d2 = b;
            branch   = 3'($urandom_range(0, 7));
            ex_valid = 1'($urandom_range(0, 1));
            #1;
            exp = ex_valid && cond_f(int'(branch), a, b);
            n_tests++;
            if (taken !== exp) begin
                n_fail++;
                $display("FAIL cond_rand br=%0d v=%b d1=%h d2=%h: got %b required %b",
                         branch, ex_valid, a, b, taken, exp);
            end
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_training();
        bit exp_pred;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ex_valid = 1'b1; stall = 1'b0; branch = 3'b010;
            ex_pc = 32'h40; if_pc = 32'h40;
            d1 = 32'd5;
            d2 = (i < 4) ? 32'd9 : 32'd5;
            ex_pred = (i < 4) ? 1'b0 : 1'b1;
            #1;
            exp_pred = pred_f(32'h40);
            n_tests++;
            if (pred_taken !== exp_pred) begin
                n_fail++;
                $display("FAIL train_pred step=%0d: got %b required %b", i, pred_taken, exp_pred);
            end
            tick();
            n_tests++;
            if (mispredict !== mis_m || br_count !== 4'(br_m) || miss_count !== 4'(miss_m)) begin
                n_fail++;
                $display("FAIL train_stats step=%0d: mis=%b br=%0d miss=%0d required %b/%0d/%0d",
                         i, mispredict, br_count, miss_count, mis_m, br_m, miss_m);
            end
        end
        idle_inputs();
        tick();
        #1;
        n_tests++;
        if (mispredict !== 1'b0 || pred_taken !== pred_f(32'h40)) begin
            n_fail++;
            $display("FAIL train_final: mis=%b pred=%b required 0/%b",
                     mispredict, pred_taken, pred_f(32'h40));
        end
    endtask

    task automatic test_hazard();
        do_reset();
        ex_valid = 1'b1; branch = 3'b001; d1 = 32'd3; d2 = 32'd3;
        ex_pc = 32'h80; if_pc = 32'h80; ex_pred = 1'b0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_same: got %b required 0", pred_taken);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_next: got %b required 1", pred_taken);
        end
    endtask

    task automatic test_stall_alias();
        do_reset();
        ex_valid = 1'b1; stall = 1'b1; branch = 3'b110; d1 = 32'd0;
        ex_pc = 32'h004; if_pc = 32'h004; ex_pred = 1'b0;
        tick(); tick();
        stall = 1'b0; ex_valid = 1'b0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b0 || mispredict !== 1'b0 || br_count !== 4'd0 ||
            miss_count !== 4'd0) begin
            n_fail++;
            $display("FAIL stall: pred=%b mis=%b br=%0d miss=%0d required 0/0/0/0",
                     pred_taken, mispredict, br_count, miss_count);
        end
        ex_valid = 1'b1; ex_pc = 32'h104;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (pred_taken !== 1'b1 || pred_taken !== pred_f(32'h004)) begin
            n_fail++;
            $display("FAIL alias: pred(0x004)=%b required 1", pred_taken);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ex_valid = 1'b1; branch = 3'b010; d1 = 32'd1; d2 = 32'd2;
            ex_pc = 32'($urandom_range(0, 63) * 4);
            ex_pred = (i % 2 == 1) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if (br_count !== 4'(br_m) || miss_count !== 4'(miss_m)) begin
                n_fail++;
                $display("FAIL sat step=%0d: br=%0d miss=%0d required %0d/%0d",
                         i, br_count, miss_count, br_m, miss_m);
            end
        end
        idle_inputs();
        n_tests++;
        if (br_count !== 4'd15 || mispredict !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: br=%0d mis=%b required 15/1", br_count, mispredict);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (mispredict !== 1'b0 || br_count !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid: mis=%b br=%0d required 0/0", mispredict, br_count);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_random();
        bit exp_t;
        bit exp_p;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 39) do_reset();
            ex_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            branch   = 3'($urandom_range(0, 7));
            ex_pred  = 1'($urandom_range(0, 1));
            ex_pc    = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            if_pc    = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            d1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            d2 = ($urandom_range(0, 2) == 0) ? d1 : $urandom;
            #1;
            exp_t = ex_valid && cond_f(int'(branch), d1, d2);
            exp_p = pred_f(if_pc);
            n_tests++;
            if (taken !== exp_t || pred_taken !== exp_p) begin
                n_fail++;
                $display("FAIL rand_comb i=%0d: taken=%b pred=%b required %b/%b",
                         i, taken, pred_taken, exp_t, exp_p);
            end
            tick();
            n_tests++;
            if (mispredict !== mis_m || br_count !== 4'(br_m) || miss_count !== 4'(miss_m)) begin
                n_fail++;
                $display("FAIL rand_seq i=%0d: mis=%b br=%0d miss=%0d required %b/%0d/%0d",
                         i, mispredict, br_count, miss_count, mis_m, br_m, miss_m);
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_conditions();
        test_training();
        test_hazard();
        test_stall_alias();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
